// File: rtl/laplace_window_gen.sv
// laplace_window_gen
//   Streaming neighbourhood generator for a 5-point Laplace kernel. Takes a
//   raster-order 8-bit pixel stream, keeps the two previous lines, and for
//   every interior centre pixel (r, c) emits the cross window
//   b=(r-1,c) d=(r,c-1) e=(r,c) f=(r,c+1) h=(r+1,c). Border pixels are never
//   emitted as centres.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready = !out_valid || out_ready
//   in_pixel              raster-order pixel
//   in_sof                marks the accepted pixel as (0,0)
//   out_valid/out_ready   output handshake; window held while stalled
//   b, d, e, f, h         window pixels
//   out_row, out_col      centre coordinates of the window
//   frame_done            one-cycle pulse after the last pixel of a frame
//
// States
//   ST_FILL | rows 0-1 (or after sof / frame end): line buffers priming, no windows
//   ST_RUN  | rows 2..IMG_H-1: each interior-column accept produces a window
module laplace_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_pixel,
    input  logic          in_sof,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    b,
    output logic [7:0]    d,
    output logic [7:0]    e,
    output logic [7:0]    f,
    output logic [7:0]    h,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          frame_done
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;

    // r_lb0 holds the line just above the incoming one, r_lb1 the line above that.
    logic [7:0]    r_lb0 [IMG_W];
    logic [7:0]    r_lb1 [IMG_W];
    logic [7:0]    r_mid_prev;

    logic          r_valid;
    logic [7:0]    r_b, r_d, r_e, r_f, r_h;
    logic [RW-1:0] r_out_row;
    logic [CW-1:0] r_out_col;
    logic          r_frame_done;

    logic          w_accept;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col_p1;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_frame_last;
    logic          w_emit;
    logic [7:0]    w_up;
    logic [7:0]    w_mid;
    logic [7:0]    w_mid_right;

    assign in_ready     = !r_valid || out_ready;
    assign w_accept     = in_valid && in_ready;

    // in_sof overrides whatever the counters hold for this one pixel.
    assign w_col        = in_sof ? '0 : r_col;
    assign w_row        = in_sof ? '0 : r_row;

    assign w_col_last   = (w_col == COL_LAST);
    assign w_row_last   = (w_row == ROW_LAST);
    assign w_frame_last = w_col_last && w_row_last;
    assign w_col_p1     = w_col_last ? '0 : w_col + 1'b1;

    // Buffer reads see the contents from before this cycle's write.
    assign w_up         = r_lb1[w_col];
    assign w_mid        = r_lb0[w_col];
    assign w_mid_right  = r_lb0[w_col_p1];

    assign w_emit       = w_accept && (r_state == ST_RUN) && (w_row >= ROW_TWO)
                          && (w_col != '0) && !w_col_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_accept && (w_row == ROW_TWO) && (w_col == '0))
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_accept && (in_sof || w_frame_last))
                    w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (w_accept) begin
            if (w_col_last) begin
                w_col_nxt = '0;
                w_row_nxt = w_row_last ? '0 : w_row + 1'b1;
            end else begin
                w_col_nxt = w_col + 1'b1;
                w_row_nxt = w_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Line buffers shift one row per column on each accept. r_mid_prev keeps
    // the previous column's middle-row pixel, because r_lb0 at that column has
    // already been overwritten with the incoming row.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_col] <= w_mid;
            r_lb0[w_col] <= in_pixel;
            r_mid_prev   <= w_mid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_b          <= '0;
            r_d          <= '0;
            r_e          <= '0;
            r_f          <= '0;
            r_h          <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_frame_last;
            // w_emit implies an accept, which implies the slot is free or draining.
            if (w_emit) begin
                r_valid   <= 1'b1;
                r_b       <= w_up;
                r_d       <= r_mid_prev;
                r_e       <= w_mid;
                r_f       <= w_mid_right;
                r_h       <= in_pixel;
                r_out_row <= w_row - 1'b1;
                r_out_col <= w_col;
            end else if (out_ready) begin
                r_valid   <= 1'b0;
            end
        end
    end

    assign out_valid  = r_valid;
    assign b          = r_b;
    assign d          = r_d;
    assign e          = r_e;
    assign f          = r_f;
    assign h          = r_h;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_laplace_window_gen.sv
module tb_laplace_window_gen;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int CW    = 2;
    localparam int RW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_pixel;
    logic          in_sof;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    b, d, e, f, h;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          frame_done;

    always #5 clk = ~clk;

    laplace_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .b          (b),
        .d          (d),
        .e          (e),
        .f          (f),
        .h          (h),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [7:0]    b;
        logic [7:0]    d;
        logic [7:0]    e;
        logic [7:0]    f;
        logic [7:0]    h;
    } win_t;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       exp_v;
        logic       exp_fd;
        win_t       exp_w;
    } vec_t;

    win_t exp_win [4];
    vec_t vecs [16];

    win_t win_q[$];
    int   win_cyc_q[$];
    int   acc_cyc_q[$];
    int   fd_cnt;
    int   fd_cyc;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record completed output handshakes and frame_done pulses, sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            win_q.push_back({out_row, out_col, b, d, e, f, h});
            win_cyc_q.push_back(cyc);
        end
        if (!rst && frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    function automatic win_t cur_win();
        return {out_row, out_col, b, d, e, f, h};
    endfunction

    function automatic logic [7:0] pix_at(input int i, input int off);
        return 8'(16 * (i / IMG_W) + (i % IMG_W) + off);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic clear_log();
        win_q.delete();
        win_cyc_q.delete();
        acc_cyc_q.delete();
        fd_cnt = 0;
        fd_cyc = -1;
    endtask

    task automatic send(input logic [7:0] pix, input logic sof);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_pixel = pix;
        in_sof   = sof;
        #1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: pixel %0h never accepted, in_ready=%0b", pix, in_ready);
        end else begin
            @(posedge clk);
            #1;
            acc_cyc_q.push_back(cyc);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic chk_windows(input string name, input int first, input int off);
        win_t w;
        for (int k = 0; k < 4; k++) begin
            w   = exp_win[k];
            w.b = w.b + 8'(off);
            w.d = w.d + 8'(off);
            w.e = w.e + 8'(off);
            w.f = w.f + 8'(off);
            w.h = w.h + 8'(off);
            if (first + k < win_q.size()) begin
                chk(name, win_q[first + k], w);
            end else begin
                n_total++;
                $display("FAIL %s: window %0d missing, got %0d windows", name, first + k, win_q.size());
            end
        end
    endtask

    initial begin
        // Hand-computed windows for pixel = 16r + c on a 4x4 frame.
        exp_win[0] = {2'd1, 2'd1, 8'd1,  8'd16, 8'd17, 8'd18, 8'd33};
        exp_win[1] = {2'd1, 2'd2, 8'd2,  8'd17, 8'd18, 8'd19, 8'd34};
        exp_win[2] = {2'd2, 2'd1, 8'd17, 8'd32, 8'd33, 8'd34, 8'd49};
        exp_win[3] = {2'd2, 2'd2, 8'd18, 8'd33, 8'd34, 8'd35, 8'd50};

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '0;
            vecs[i].pix = pix_at(i, 0);
        end
        vecs[0].sof    = 1'b1;
        vecs[9].exp_v  = 1'b1;  vecs[9].exp_w  = exp_win[0];
        vecs[10].exp_v = 1'b1;  vecs[10].exp_w = exp_win[1];
        vecs[13].exp_v = 1'b1;  vecs[13].exp_w = exp_win[2];
        vecs[14].exp_v = 1'b1;  vecs[14].exp_w = exp_win[3];
        vecs[15].exp_fd = 1'b1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        clear_log();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_outputs", cur_win(), 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Basic window, continuous stream
        clear_log();
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].pix, vecs[i].sof);
            chk($sformatf("basic_valid_%0d", i), out_valid, vecs[i].exp_v);
            chk($sformatf("basic_fd_%0d", i), frame_done, vecs[i].exp_fd);
            if (vecs[i].exp_v) chk($sformatf("basic_win_%0d", i), cur_win(), vecs[i].exp_w);
        end
        repeat (2) @(negedge clk);
        chk("basic_count", win_q.size(), 4);
        chk_windows("basic_order", 0, 0);
        if (win_cyc_q.size() > 0 && acc_cyc_q.size() > 9)
            chk("basic_first_latency", win_cyc_q[0], acc_cyc_q[9]);
        chk("basic_fd_count", fd_cnt, 1);
        if (acc_cyc_q.size() > 15) chk("basic_fd_timing", fd_cyc, acc_cyc_q[15]);

        // Backpressure: stall with a window held
        clear_log();
        for (int i = 0; i < 10; i++) send(pix_at(i, 0), i == 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = pix_at(10, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_in_ready_%0d", k), in_ready, 0);
            chk($sformatf("bp_valid_%0d", k), out_valid, 1);
            chk($sformatf("bp_hold_%0d", k), cur_win(), exp_win[0]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_release_win", cur_win(), exp_win[1]);
        chk("bp_release_valid", out_valid, 1);
        for (int i = 11; i < 16; i++) send(pix_at(i, 0), 1'b0);
        repeat (2) @(negedge clk);
        chk("bp_count", win_q.size(), 4);
        chk_windows("bp_order", 0, 0);

        // Gaps on in_valid
        clear_log();
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(pix_at(i, 0), i == 0);
        end
        repeat (2) @(negedge clk);
        chk("gap_count", win_q.size(), 4);
        chk_windows("gap_order", 0, 0);
        chk("gap_fd_count", fd_cnt, 1);

        // Back-to-back frames, second offset by 100, relying on counter wrap
        clear_log();
        for (int fr = 0; fr < 2; fr++)
            for (int i = 0; i < 16; i++) send(pix_at(i, fr * 100), (fr == 0) && (i == 0));
        repeat (2) @(negedge clk);
        chk("b2b_count", win_q.size(), 8);
        chk_windows("b2b_frame0", 0, 0);
        chk_windows("b2b_frame1", 4, 100);
        if (win_q.size() > 4) begin
            chk("b2b_w5_e", win_q[4].e, 117);
            chk("b2b_w5_b", win_q[4].b, 101);
            chk("b2b_w5_h", win_q[4].h, 133);
        end
        chk("b2b_fd_count", fd_cnt, 2);

        // in_sof mid-frame restarts the frame
        clear_log();
        for (int i = 0; i < 6; i++) send(8'hE0 + 8'(i), i == 0);
        for (int i = 0; i < 9; i++) send(pix_at(i, 0), i == 0);
        @(negedge clk);
        #1;
        chk("sof_no_early_win", win_q.size(), 0);
        chk("sof_no_early_valid", out_valid, 0);
        send(pix_at(9, 0), 1'b0);
        chk("sof_first_win", cur_win(), exp_win[0]);
        for (int i = 10; i < 16; i++) send(pix_at(i, 0), 1'b0);
        repeat (2) @(negedge clk);
        chk("sof_count", win_q.size(), 4);
        chk_windows("sof_order", 0, 0);
        chk("sof_fd_count", fd_cnt, 1);

        // Reset mid-RUN
        clear_log();
        for (int i = 0; i < 10; i++) send(pix_at(i, 0), i == 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_outputs", cur_win(), 0);
        chk("mid_rst_fd", frame_done, 0);
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 16; i++) send(pix_at(i, 0), 1'b0);
        repeat (2) @(negedge clk);
        chk("post_rst_count", win_q.size(), 4);
        chk_windows("post_rst_order", 0, 0);
        chk("post_rst_fd_count", fd_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/laplace_window_gen.md
Name: laplace_window_gen

Overview:
- Streaming neighbourhood generator that sits in front of the 5-point Laplace kernel.
- Accepts a raster-order 8-bit pixel stream and buffers two lines.
- Emits, per interior pixel, the cross window b (up), d (left), e (centre), f (right), h (down), ready for the kernel's b/d/e/f/h inputs.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) are never emitted as centres.

Parameters:
IMG_W, 640, pixels per line (>= 3)
IMG_H, 480, lines per frame (>= 3)
CW, $clog2(IMG_W), column counter width (derived)
RW, $clog2(IMG_H), row counter width (derived)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  pixel present on in_pixel
in_ready  out  1  block can accept a pixel this cycle
in_pixel  in  8  raster-order pixel, unsigned
in_sof  in  1  qualifies with in_valid: this pixel is (row 0, col 0)
out_valid  out  1  window on b/d/e/f/h is valid
out_ready  in  1  downstream accepts window
b  out  8  pixel (r-1, c)
d  out  8  pixel (r, c-1)
e  out  8  pixel (r, c)
f  out  8  pixel (r, c+1)
h  out  8  pixel (r+1, c)
out_row  out  RW  centre row r
out_col  out  CW  centre column c
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, frame_done=0, b/d/e/f/h=0, out_row=0, out_col=0. Row/col counters=0, state=FILL. Line-buffer contents are don't-care. Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Output registers hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new window is produced in the same cycle.
- Counters:
  - col increments per accept; at col=IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0.
  - in_sof on an accepted pixel forces that pixel to be treated as (0,0), whatever the counters hold. The counters then continue from (0,1).
- Line storage:
  - Two line buffers hold rows r and r-1 relative to the incoming row r+1.
  - Written at the column of each accepted pixel.
  - Reads and writes to the same column in the same cycle return the old data.
- Window emission:
  - Accepting pixel (R,C) with 2 <= R <= IMG_H-1 and 1 <= C <= IMG_W-2 produces the window centred at (R-1, C).
  - Window contents: b=(R-2,C), d=(R-1,C-1), e=(R-1,C), f=(R-1,C+1), h=(R,C).
  - Latency: out_valid=1 on the cycle after the accept.
  - Exactly (IMG_W-2)*(IMG_H-2) windows per frame, in raster order of centre.
- State machine:
  - FILL: rows 0-1, no emission. Moves to RUN on accepting (2,0).
  - RUN: emits per the rule above.
  - Returns to FILL after accepting (IMG_H-1, IMG_W-1) or on in_sof.
- frame_done: asserted for exactly one cycle, the cycle after accepting (IMG_H-1, IMG_W-1). Independent of out_ready.
- Back-to-back frames: no bubble is required. Pixel (0,0) of the next frame may be accepted on the cycle after the last pixel of the previous frame.
- No arithmetic on pixel values; all data is passed through unchanged.

Test Plan:
- Basic window (IMG_W=4, IMG_H=4, pixel=16r+c, in_valid=1, out_ready=1): accept 16 pixels -> 4 windows. The first appears the cycle after the 10th accept with b=1, d=16, e=17, f=18, h=33, row=1, col=1. The last has b=18, d=33, e=34, f=35, h=50, row=2, col=2. frame_done pulses the cycle after the 16th accept.
- Backpressure: out_ready=0 for 5 cycles while a window is valid -> in_ready=0, window held unchanged. Then out_ready=1 -> next pixel accepted, and no window is lost or duplicated.
- Gaps (in_valid toggled 1/0 randomly) -> same 4 windows, same values, same order as in the basic-window scenario.
- Back-to-back frames with the second frame's pixels +100 -> 8 windows total. The 5th window has e=117, b=101, h=133. Exactly two frame_done pulses.
- in_sof asserted at pixel index 6 of a frame -> state returns to FILL, that pixel is treated as (0,0), and no window is emitted until (2,1) of the new frame.
- rst asserted for 1 cycle mid-RUN -> out_valid=0, outputs=0 next cycle. A full frame afterward gives the exact expected results of the basic-window scenario.
